// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller for the analog SAR ADC: track/hold, DAC trial codes,
// comparator synchronization and valid/ready result delivery. Define SAR_AVG_EN to average 4 conversions per result.
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             cmp_in,
    output logic             sample_o,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun
);

    localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES + 2) ? SAMPLE_CYCLES : SETTLE_CYCLES + 2;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(WIDTH);

    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES + 1);
    localparam logic [IW-1:0] MSB_IDX     = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        DECIDE,
        DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [IW-1:0]      bit_reg, bit_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [1:0]         sync_reg;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               valid_reg, valid_next;
    logic               overrun_reg, overrun_next;

    logic               cmp_sync;
    logic [WIDTH-1:0]   trial;
    logic [WIDTH-1:0]   acc_final;
    logic               load;
    logic [WIDTH-1:0]   load_data;

`ifdef SAR_AVG_EN
    logic [WIDTH+1:0]   sum_reg, sum_next;
    logic [1:0]         conv_reg, conv_next;
    logic [WIDTH+1:0]   sum_total;
`endif

    assign cmp_sync  = sync_reg[1];
    assign trial     = acc_reg | ({{(WIDTH-1){1'b0}}, 1'b1} << bit_reg);
    assign acc_final = acc_reg | ({{(WIDTH-1){1'b0}}, cmp_sync} << bit_reg);
`ifdef SAR_AVG_EN
    assign sum_total = sum_reg + {2'b00, acc_final};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            acc_reg     <= '0;
            sync_reg    <= '0;
            result_reg  <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
`ifdef SAR_AVG_EN
            sum_reg     <= '0;
            conv_reg    <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_reg     <= bit_next;
            acc_reg     <= acc_next;
            sync_reg    <= {sync_reg[0], cmp_in};
            result_reg  <= result_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
`ifdef SAR_AVG_EN
            sum_reg     <= sum_next;
            conv_reg    <= conv_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_next     = bit_reg;
        acc_next     = acc_reg;
        result_next  = result_reg;
        valid_next   = valid_reg;
        overrun_next = 1'b0;
        sample_o     = 1'b0;
        dac_code     = '0;
        busy         = (state_reg != IDLE);
        load         = 1'b0;
        load_data    = acc_final;
`ifdef SAR_AVG_EN
        sum_next     = sum_reg;
        conv_next    = conv_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SAMPLE;
                    cnt_next   = '0;
                    bit_next   = MSB_IDX;
                    acc_next   = '0;
`ifdef SAR_AVG_EN
                    sum_next   = '0;
                    conv_next  = '0;
`endif
                end
            end
            SAMPLE: begin
                sample_o = 1'b1;
                if (cnt_reg == SAMPLE_LAST) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            SETTLE: begin
                dac_code = trial;
                if (cnt_reg == SETTLE_LAST) begin
                    state_next = DECIDE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DECIDE: begin
                dac_code = trial;
                acc_next = acc_final;
                if (bit_reg == '0) begin
`ifdef SAR_AVG_EN
                    if (conv_reg == 2'd3) begin
                        load       = 1'b1;
                        load_data  = sum_total[WIDTH+1:2];
                        state_next = DONE;
                    end else begin
                        sum_next   = sum_total;
                        conv_next  = conv_reg + 2'd1;
                        state_next = SAMPLE;
                        cnt_next   = '0;
                        bit_next   = MSB_IDX;
                        acc_next   = '0;
                    end
`else
                    load       = 1'b1;
                    state_next = DONE;
`endif
                end else begin
                    bit_next   = bit_reg - IW'(1);
                    state_next = SETTLE;
                end
            end
            DONE: begin
                dac_code = acc_reg;
                if (cont) begin
                    state_next = SAMPLE;
                    cnt_next   = '0;
                    bit_next   = MSB_IDX;
                    acc_next   = '0;
`ifdef SAR_AVG_EN
                    sum_next   = '0;
                    conv_next  = '0;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // A new result lands on the edge entering DONE; it wins over a same-cycle consume.
        if (load) begin
            result_next  = load_data;
            valid_next   = 1'b1;
            overrun_next = valid_reg && !result_ready;
        end else if (valid_reg && result_ready) begin
            valid_next = 1'b0;
        end
    end

    assign result       = result_reg;
    assign result_valid = valid_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl with an ideal comparator model cmp = (vin >= dac_code).
module tb_sar_adc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cont;
    logic       cmp_in;
    logic       sample_o;
    logic [7:0] dac_code;
    logic       busy;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ready;
    logic       overrun;

    logic [7:0] vin;
    logic       alt_en;
    int         n_compared = 0;
    int         n_mismatched = 0;
    logic [7:0] trials[$];
    logic [7:0] prev_dac;

    always #5 clk = ~clk;

    assign cmp_in = (vin >= dac_code);

    sar_adc_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .cont(cont),
        .cmp_in(cmp_in),
        .sample_o(sample_o),
        .dac_code(dac_code),
        .busy(busy),
        .result(result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .overrun(overrun)
    );

    // Alternates the analog input at the start of every SAMPLE phase (averaging test).
    always @(posedge sample_o) begin
        if (alt_en) vin = (vin == 8'h40) ? 8'h43 : 8'h40;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Leaves the bench #1 after the edge that accepted start (cycle 1 of the conversion).
    task automatic start_conv(input logic [7:0] v);
        vin = v;
        trials.delete();
        prev_dac = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycles until result_valid is seen, counting the start cycle as 0; records DAC trial codes.
    task automatic wait_valid(input int max_cycles, output int n);
        n = 1;
        while (!result_valid && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
            if (dac_code != prev_dac && dac_code != 8'h00) trials.push_back(dac_code);
            prev_dac = dac_code;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_trials [8];
    int         lat;
    logic       seen_valid;

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        cont         = 1'b0;
        result_ready = 1'b0;
        vin          = 8'h00;
        alt_en       = 1'b0;
        prev_dac     = 8'h00;
        exp_trials   = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        tick(3);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_sample", sample_o, 0);
        check_eq("rst_dac", dac_code, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_valid", result_valid, 0);
        check_eq("rst_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

`ifdef SAR_AVG_EN
        vin    = 8'h43;
        alt_en = 1'b1;
        start_conv(8'h43);
        wait_valid(400, lat);
        check_eq("avg_latency", lat, 145);
        check_eq("avg_result", result, 8'h41);
        check_eq("avg_overrun", overrun, 0);
        tick(1);
        check_eq("avg_busy_after", busy, 0);
        alt_en = 1'b0;
`else
        // Single conversion of 0xA5: latency, trial sequence, result.
        start_conv(8'hA5);
        check_eq("busy_rise", busy, 1);
        check_eq("sample_hi", sample_o, 1);
        wait_valid(200, lat);
        check_eq("a5_latency", lat, 37);
        check_eq("a5_result", result, 8'hA5);
        check_eq("a5_done_dac", dac_code, 8'hA5);
        check_eq("a5_ntrials", trials.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("a5_trial%0d", k), (k < trials.size()) ? trials[k] : 8'hXX, exp_trials[k]);
        end
        tick(1);
        check_eq("a5_busy_after", busy, 0);
        check_eq("a5_valid_held", result_valid, 1);
        consume();
        check_eq("a5_valid_clr", result_valid, 0);

        // Full-scale corners.
        start_conv(8'h00);
        wait_valid(200, lat);
        check_eq("zero_result", result, 8'h00);
        tick(1);
        check_eq("zero_busy_after", busy, 0);
        consume();
        start_conv(8'hFF);
        wait_valid(200, lat);
        check_eq("ff_latency", lat, 37);
        check_eq("ff_result", result, 8'hFF);
        tick(1);
        check_eq("ff_busy_after", busy, 0);
        consume();

        // Continuous mode with no consumer: overwrite and overrun.
        cont = 1'b1;
        start_conv(8'h10);
        wait_valid(200, lat);
        check_eq("cont1_result", result, 8'h10);
        check_eq("cont1_overrun", overrun, 0);
        vin = 8'h20;
        tick(1);
        check_eq("cont1_ovr_low", overrun, 0);
        tick(35);
        check_eq("cont2_pre_ovr", overrun, 0);
        tick(1);
        check_eq("cont2_overrun", overrun, 1);
        check_eq("cont2_result", result, 8'h20);
        check_eq("cont2_valid", result_valid, 1);
        vin = 8'h30;
        tick(1);
        check_eq("cont2_ovr_pulse", overrun, 0);
        tick(36);
        check_eq("cont3_overrun", overrun, 1);
        check_eq("cont3_result", result, 8'h30);
        check_eq("cont3_valid", result_valid, 1);
        cont = 1'b0;
        tick(1);
        check_eq("cont3_busy_after", busy, 0);
        consume();

        // Consumer ready on the load cycle: new data replaces old, valid stays, no overrun.
        cont = 1'b1;
        start_conv(8'h55);
        wait_valid(200, lat);
        check_eq("rdy1_result", result, 8'h55);
        vin = 8'h66;
        tick(36);
        result_ready = 1'b1;
        tick(1);
        result_ready = 1'b0;
        cont = 1'b0;
        check_eq("rdy2_result", result, 8'h66);
        check_eq("rdy2_valid", result_valid, 1);
        check_eq("rdy2_overrun", overrun, 0);
        tick(1);
        consume();
        check_eq("rdy2_valid_clr", result_valid, 0);

        // start during a conversion is ignored.
        start_conv(8'h3C);
        tick(9);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        lat = 11;
        while (!result_valid && lat < 200) begin
            tick(1);
            lat++;
        end
        check_eq("ign_latency", lat, 37);
        check_eq("ign_result", result, 8'h3C);
        consume();
        seen_valid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick(1);
            if (result_valid) seen_valid = 1'b1;
        end
        check_eq("ign_single", seen_valid, 0);
        check_eq("ign_idle", busy, 0);

        // Reset at cycle 20 of a conversion.
        start_conv(8'h77);
        tick(19);
        check_eq("mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_dac", dac_code, 0);
        check_eq("mid_rst_sample", sample_o, 0);
        check_eq("mid_rst_result", result, 0);
        check_eq("mid_rst_valid", result_valid, 0);
        check_eq("mid_rst_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick(1);
            if (result_valid) seen_valid = 1'b1;
        end
        check_eq("mid_no_result", seen_valid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
